otp_stream_cipher: RTL and testbench

OTP_STREAM_CIPHER -- requirements
Module: otp_stream_cipher

---
 rtl/otp_pkg.sv | 18 +
 rtl/otp_key_ram.sv | 46 ++++
 rtl/otp_stream_cipher.sv | 133 +++++++++++++
 tb/tb_otp_stream_cipher.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/otp_pkg.sv
// Shared types and defaults for the one-time-pad stream cipher.
// OTP_STRICT_KEY_EN adds the HALT state for strict no-reuse keys.
package otp_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int KEY_DEPTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
`ifdef OTP_STRICT_KEY_EN
    ,
    ST_HALT  = 2'd3
`endif
  } state_t;

endpackage

// File: rtl/otp_key_ram.sv
// Key symbol store: append-only write port, async read, fill count.
// Contents are not reset; only the count is.
module otp_key_ram
  import otp_pkg::*;
#(
  parameter int  DATA_W    = DATA_W_DEF,
  parameter int  KEY_DEPTH = KEY_DEPTH_DEF,
  localparam int CNT_W     = $clog2(KEY_DEPTH + 1),
  localparam int AW        = (KEY_DEPTH > 1) ?
                             $clog2(KEY_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              clr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [KEY_DEPTH];
  logic              full;
  logic              push;

  assign full    = (count == CNT_W'(KEY_DEPTH));
  assign push    = wr && !clr && !full;
  assign rd_data = mem[rd_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (push) begin
      count <= count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[count[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/otp_stream_cipher.sv
// XOR stream cipher with a loadable key store and valid/ready streams.
// OTP_STRICT_KEY_EN halts instead of wrapping the key.
module otp_stream_cipher
  import otp_pkg::*;
#(
  parameter int  DATA_W    = DATA_W_DEF,
  parameter int  KEY_DEPTH = KEY_DEPTH_DEF,
  localparam int CNT_W     = $clog2(KEY_DEPTH + 1),
  localparam int AW        = (KEY_DEPTH > 1) ?
                             $clog2(KEY_DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_wr,
  input  logic [DATA_W-1:0] key_data,
  input  logic              key_clr,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  key_count,
  output logic              key_exhausted
);

  state_t            state;
  state_t            state_nx;
  logic [AW-1:0]     ptr;
  logic [DATA_W-1:0] key_sym;
  logic              idle;
  logic              go;
  logic              accept;
  logic              last;

  assign idle     = (state == ST_IDLE);
  assign busy     = !idle;
  assign go       = idle && start && (key_count != '0);
  assign in_ready = (state == ST_RUN) &&
                    (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign last     = (CNT_W'(ptr) ==
                     key_count - CNT_W'(1));

  otp_key_ram #(
    .DATA_W    (DATA_W),
    .KEY_DEPTH (KEY_DEPTH)
  ) u_key_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr      (idle && key_wr),
    .clr     (idle && key_clr),
    .wr_data (key_data),
    .rd_addr (ptr),
    .rd_data (key_sym),
    .count   (key_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (go) state_nx = ST_RUN;
      end
      ST_RUN: begin
`ifdef OTP_STRICT_KEY_EN
        if (accept && last) state_nx = ST_HALT;
        else if (stop)      state_nx = ST_DRAIN;
`else
        if (stop) state_nx = ST_DRAIN;
`endif
      end
      ST_DRAIN: begin
        if (!out_valid) state_nx = ST_IDLE;
      end
`ifdef OTP_STRICT_KEY_EN
      // Leave through DRAIN so a pending output still gets delivered.
      ST_HALT: begin
        if (stop) state_nx = ST_DRAIN;
      end
`endif
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (go) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= last ? '0 : ptr + AW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ key_sym;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef OTP_STRICT_KEY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_exhausted <= 1'b0;
    end else if (idle && (start || key_clr)) begin
      key_exhausted <= 1'b0;
    end else if (accept && last) begin
      key_exhausted <= 1'b1;
    end
  end
`else
  assign key_exhausted = 1'b0;
`endif

endmodule

// File: tb/tb_otp_stream_cipher.sv
// Scoreboard bench for otp_stream_cipher (default 8-bit symbols).
// Strict-key checks build only with OTP_STRICT_KEY_EN defined.
module tb_otp_stream_cipher;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_wr = 1'b0;
  logic [7:0] key_data = '0;
  logic       key_clr = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_data;
  logic       busy;
  logic [3:0] key_count;
  logic       key_exhausted;

  int checks = 0;
  int failures = 0;

  logic [7:0] key_m[$];
  int         kptr = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         stall_seen = 0;

  always #5 clk = ~clk;

  otp_stream_cipher dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_wr        (key_wr),
    .key_data      (key_data),
    .key_clr       (key_clr),
    .start         (start),
    .stop          (stop),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .busy          (busy),
    .key_count     (key_count),
    .key_exhausted (key_exhausted)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load_key(input logic [7:0] k[$]);
    key_m = k;
    foreach (k[i]) begin
      @(negedge clk);
      key_wr   = 1'b1;
      key_data = k[i];
    end
    @(negedge clk);
    key_wr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    kptr = 0;
  endtask

  task automatic stop_and_idle(input string tag);
    int n;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, busy, 0);
  endtask

  // Drive src through the DUT; out_ready is low for 3 cycles at stall_at.
  task automatic stream(input logic [7:0] src[$],
                        input int stall_at,
                        input int max_cyc,
                        input bit open_end);
    int i;
    int cyc;
    bit have_hold;
    logic [7:0] hold;
    i = 0;
    cyc = 0;
    have_hold = 0;
    hold = '0;
    stall_seen = 0;
    got_q.delete();
    while ((i < src.size() || exp_q.size() > 0)
           && cyc < max_cyc) begin
      @(negedge clk);
      in_valid  = (i < src.size());
      in_data   = in_valid ? src[i] : 8'h00;
      out_ready = !(cyc >= stall_at && cyc < stall_at + 3);
      #1;
      if (out_valid && !out_ready) begin
        stall_seen++;
        check("stall_in_ready", in_ready, 0);
        if (have_hold) check("stall_hold", out_data, hold);
        else begin
          hold = out_data;
          have_hold = 1;
        end
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_out", out_data, 32'hFFFF_FFFF);
        end else begin
          check("sb_data", out_data, exp_q.pop_front());
          got_q.push_back(out_data);
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data ^ key_m[kptr]);
        kptr = (kptr + 1) % key_m.size();
        i++;
      end
      cyc++;
    end
    if (!open_end) begin
      check("accepted", i, src.size());
      check("sb_empty", exp_q.size(), 0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  logic [7:0] cinc[$] = '{8'h63, 8'h69, 8'h6E, 8'h63};
  logic [7:0] pt[$]   = '{8'h74, 8'h72, 8'h61, 8'h62,
                          8'h61, 8'h6C, 8'h68, 8'h6F};
  logic [7:0] ct[$]   = '{8'h17, 8'h1B, 8'h0F, 8'h01,
                          8'h02, 8'h05, 8'h06, 8'h0C};
  logic [7:0] full9[$] = '{8'h01, 8'h02, 8'h03, 8'h04,
                           8'h05, 8'h06, 8'h07, 8'h08,
                           8'h09};
  logic [7:0] one[$]  = '{8'hA5};

  initial begin
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_key_count", key_count, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_exhausted", key_exhausted, 0);
    @(negedge clk);
    rst_n = 1'b1;

    pulse_start();
    #1;
    check("start_empty_busy", busy, 0);

    load_key(one);
    check("one_key_count", key_count, 1);
    @(negedge clk);
    key_clr  = 1'b1;
    key_wr   = 1'b1;
    key_data = 8'h55;
    @(negedge clk);
    key_clr = 1'b0;
    key_wr  = 1'b0;
    check("clr_prio_count", key_count, 0);

    load_key(full9);
    check("full_count", key_count, 8);
    @(negedge clk);
    key_clr = 1'b1;
    @(negedge clk);
    key_clr = 1'b0;

    load_key(cinc);
    check("cinc_count", key_count, 4);
    pulse_start();
    #1;
    check("run_busy", busy, 1);

`ifdef OTP_STRICT_KEY_EN
    stream(pt[0:5], 100, 30, 1'b1);
    check("strict_outputs", got_q.size(), 4);
    foreach (got_q[k]) check("strict_vec", got_q[k], ct[k]);
    check("strict_exhausted", key_exhausted, 1);
    check("strict_in_ready", in_ready, 0);
    check("strict_busy", busy, 1);
    exp_q.delete();
    stop_and_idle("strict_idle");
    pulse_start();
    #1;
    check("strict_restart_clr", key_exhausted, 0);
    stop_and_idle("strict_idle2");
`else
    stream(pt, 3, 200, 1'b0);
    check("enc_outputs", got_q.size(), 8);
    check("stall_cycles", stall_seen, 3);
    foreach (got_q[k]) check("enc_vec", got_q[k], ct[k]);
    check("no_exhaust", key_exhausted, 0);
    @(negedge clk);
    key_wr   = 1'b1;
    key_data = 8'h77;
    @(negedge clk);
    key_wr = 1'b0;
    check("wr_ignored_run", key_count, 4);
    stop_and_idle("enc_idle");

    pulse_start();
    stream(ct, 100, 200, 1'b0);
    check("dec_outputs", got_q.size(), 8);
    foreach (got_q[k]) check("dec_vec", got_q[k], pt[k]);
    stop_and_idle("dec_idle");
`endif

    pulse_start();
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 8'h74;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_key_count", key_count, 0);
    check("mid_rst_exhausted", key_exhausted, 0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
